inv_key_scheduler: RTL and testbench
====================================

// Module: inv_key_scheduler
// PURPOSE
//  Sequential AES-128 round-key generator for the decryptor datapath: emits round keys
//  in reverse order (round NR down to 0) over a valid/ready handshake, one key per
//  accepted transfer. It either forward-expands the cipher key to round NR first, or
//  starts directly from a cached round-NR key. Steps back with the inverse key schedule.
//  Reuses the codebase SBOX (4 instances, time-shared between forward and inverse steps).
// PARAMETERS
//  NR   10   number of rounds; legal range 1..10
// PORTS
//  clk        in   1    clock; all state changes on posedge
//  rst        in   1    synchronous active-low reset
//  start      in   1    1-cycle request; sampled only in IDLE
//  load_last  in   1    qualifies start: 0 = key_in is cipher key, 1 = key_in is round-NR key
//  key_in     in   128  key, column-major, w0 = key_in[127:96]
//  busy       out  1    high in any state other than IDLE
//  rk_valid   out  1    rk_out/rk_round valid
//  rk_ready   in   1    consumer accepts when rk_valid & rk_ready
//  rk_out     out  128  current round key, same word order as key_in
//  rk_round   out  4    round index of rk_out (NR..0)
//  done       out  1    1-cycle pulse after the round-0 key is accepted
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, busy=0, rk_valid=0, rk_out=0, rk_round=0, done=0.
//   Reset mid-operation aborts unconditionally; no partial key is emitted afterwards.
//  Rcon LUT indexed by round r=1..10: 01,02,04,08,10,20,40,80,1B,36.
//  Forward step: F(k,r) = standard AES-128 expansion round.
//   w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon[r],24'h0}; w5 = w4^w1; w6 = w5^w2; w7 = w6^w3.
//  Inverse step: I(k,r) maps the round-r key back to the round-(r-1) key.
//   w3' = w3^w2; w2' = w2^w1; w1' = w1^w0; w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon[r],24'h0}.
//  SBOX input mux:
//   EXPAND selects w3 of the key register.
//   OUT selects w3^w2 of the key register.
//   RotWord is applied in the same byte order as the forward schedule.
//  FSM states: IDLE, EXPAND, OUT.
//   IDLE: on start, key_reg <= key_in.
//    If load_last=0: cnt <= 0, next state EXPAND.
//    If load_last=1: cnt <= NR, next state OUT.
//    No start: hold.
//   EXPAND: each cycle key_reg <= F(key_reg, cnt+1) and cnt <= cnt+1.
//    Moves to OUT on the cycle cnt becomes NR (NR cycles in EXPAND).
//   OUT: rk_valid=1, rk_out=key_reg, rk_round=cnt.
//    On handshake with cnt>0: key_reg <= I(key_reg, cnt) and cnt <= cnt-1; stay in OUT.
//    On handshake with cnt==0: next state IDLE, rk_valid drops, done=1 for one cycle.
//  Latency:
//   start at edge t (load_last=0) -> rk_valid first high after edge t+1+NR (11 cycles for NR=10).
//   load_last=1 -> rk_valid high after edge t+1.
//  Throughput: with rk_ready held high, one key per cycle. NR+1 keys in NR+1 consecutive cycles.
//  Backpressure: while rk_valid & !rk_ready, rk_out and rk_round hold stable; no key is skipped.
//  start asserted while busy is ignored; key_in is sampled only at the accepting edge.
//  rk_out and rk_round are registered (driven from key_reg/cnt); no combinational path
//   from rk_ready to rk_out.
//  After done, rk_out and rk_round retain the round-0 values until the next start or reset.
//  cnt is 4 bits and never wraps: it saturates at NR in EXPAND and terminates at 0 in OUT.
// TESTING
//  1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, load_last=0, ready=1
//     -> first key at +11 cycles, rk_round=10, d014f9a8c9ee2589e13f0cc8b6630ca6;
//     next key round 9, ac7766f319fadc2128d12941575c006e;
//     round 1 key a0fafe1788542cb123a339392a6c7605;
//     round 0 key equals key_in; then a done pulse.
//  2. load_last=1, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6
//     -> rk_valid after 1 cycle; same 11-key sequence as test 1, ending at
//     2b7e151628aed2a6abf7158809cf4f3c.
//  3. Random rk_ready backpressure -> exactly 11 handshakes; rk_out/rk_round stable while
//     stalled; sequence identical to test 1.
//  4. start pulsed during EXPAND and OUT with a different key_in -> ignored;
//     output sequence unchanged.
//  5. rst=0 during EXPAND and again during OUT (after 3 keys)
//     -> next cycle IDLE, all outputs 0; a fresh start runs correctly.
//  6. Random keys vs. reference model, both load modes
//     -> every emitted key matches the model; round-0 key equals the original key.

Source files
------------

// File: rtl/inv_key_scheduler.sv
// Sequential AES-128 round-key generator for the decryptor datapath.
// Emits round keys NR down to 0 over a valid/ready handshake, either after
// forward-expanding the cipher key or directly from a cached round-NR key.
// Four S-box instances are time-shared between forward and inverse steps.

// AES forward S-box, purely combinational lookup.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX[i_byte];

endmodule

module inv_key_scheduler #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         load_last,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_OUT
    } state_t;

    localparam logic [3:0] NR_CNT = 4'(NR);

    state_t       r_state;
    logic [127:0] r_key;
    logic [3:0]   r_cnt;
    logic         r_done;

    state_t       w_state_nxt;
    logic [127:0] w_key_nxt;
    logic [3:0]   w_cnt_nxt;
    logic         w_done_nxt;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_w32;
    logic [31:0]  w_sub_in, w_rot, w_sub, w_mix;
    logic [31:0]  w_f4, w_f5, w_f6, w_f7;
    logic [127:0] w_fwd, w_inv;
    logic [3:0]   w_cnt_inc, w_rcon_idx;
    logic [7:0]   w_rcon;
    logic         w_hs;

    function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign w_w0  = r_key[127:96];
    assign w_w1  = r_key[95:64];
    assign w_w2  = r_key[63:32];
    assign w_w3  = r_key[31:0];
    assign w_w32 = w_w3 ^ w_w2;

    // The inverse step needs SubWord of the recovered w3, which is w3^w2.
    assign w_sub_in = (r_state == S_OUT) ? w_w32 : w_w3;
    assign w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    // Forward step produces round cnt+1; inverse step undoes round cnt.
    assign w_cnt_inc  = r_cnt + 4'd1;
    assign w_rcon_idx = (r_state == S_OUT) ? r_cnt : w_cnt_inc;
    assign w_rcon     = rcon_lut(w_rcon_idx);
    assign w_mix      = w_sub ^ {w_rcon, 24'h000000};

    assign w_f4  = w_w0 ^ w_mix;
    assign w_f5  = w_f4 ^ w_w1;
    assign w_f6  = w_f5 ^ w_w2;
    assign w_f7  = w_f6 ^ w_w3;
    assign w_fwd = {w_f4, w_f5, w_f6, w_f7};
    assign w_inv = {w_w0 ^ w_mix, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w32};

    assign w_hs = rk_valid & rk_ready;

    // Next-state, next-key and next-count decode for the three-state sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_key_nxt = key_in;
                    if (load_last) begin
                        w_cnt_nxt   = NR_CNT;
                        w_state_nxt = S_OUT;
                    end else begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_EXPAND;
                    end
                end
            end
            S_EXPAND: begin
                w_key_nxt = w_fwd;
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == NR_CNT) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (w_hs) begin
                    if (r_cnt != 4'd0) begin
                        w_key_nxt = w_inv;
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, key and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            // NOTE: the key register is reset too, because rk_out must read zero after reset.
            r_key   <= '0;
            r_cnt   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign rk_valid = (r_state == S_OUT);
    assign rk_out   = r_key;
    assign rk_round = r_cnt;
    assign done     = r_done;

endmodule

// File: tb/tb_inv_key_scheduler.sv
// Self-checking bench for inv_key_scheduler: FIPS-197 vector table, scoreboard
// driven random runs with backpressure, start-while-busy and mid-run reset.
module tb_inv_key_scheduler;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         load_last;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_ref [256];
    logic [127:0] rk_exp [0:NR];

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        logic         ll;
        logic [127:0] key_in;
        logic [127:0] r10;
        logic [127:0] r9;
        logic [127:0] r1;
        logic [127:0] r0;
    } vec_t;
    vec_t vectors [2];

    always #5 clk = ~clk;

    inv_key_scheduler #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_last (load_last),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .done      (done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] x, inv, b;
        for (int i = 0; i < 256; i++) begin
            x   = 8'(i);
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                if (gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
            end
            b = inv;
            sbox_ref[i] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                            ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    // Standard forward expansion of a cipher key into rk_exp[0..NR].
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rc;
        rc   = 8'h01;
        w[0] = k[127:96];
        w[1] = k[95:64];
        w[2] = k[63:32];
        w[3] = k[31:0];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) begin
            rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  128'(busy),     128'd0);
        check({tag, "_valid"}, 128'(rk_valid), 128'd0);
        check({tag, "_done"},  128'(done),     128'd0);
        check({tag, "_round"}, 128'(rk_round), 128'd0);
        check({tag, "_key"},   rk_out,         128'd0);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_start(input logic ll, input logic [127:0] k);
        start     = 1'b1;
        load_last = ll;
        key_in    = k;
        @(negedge clk);
        start     = 1'b0;
        load_last = ~ll;
        key_in    = rand_key();
    endtask

    // Counts cycles from the accepting edge until rk_valid, optionally poking start.
    task automatic wait_valid(input bit poke, output int lat);
        lat = 1;
        while (!rk_valid && lat < 200) begin
            if (poke && lat == 3) begin
                start     = 1'b1;
                key_in    = rand_key();
                load_last = $urandom_range(1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    // Full scoreboard-checked operation for cipher key k.
    task automatic run_op(input logic [127:0] k, input logic ll, input int stall_pct, input bit poke);
        exp_t       e;
        int         lat, hs, cyc;
        bit         stalled, rdy;
        logic [127:0] held_key;
        logic [3:0]   held_round;
        model_expand(k);
        for (int r = NR; r >= 0; r--) begin
            e.round = 4'(r);
            e.key   = rk_exp[r];
            sb.push_back(e);
        end
        send_start(ll, ll ? rk_exp[NR] : k);
        check("busy_after_start", 128'(busy), 128'd1);
        wait_valid(poke, lat);
        check("latency", 128'(lat), ll ? 128'd1 : 128'(NR + 1));
        hs         = 0;
        cyc        = 0;
        stalled    = 1'b0;
        held_key   = '0;
        held_round = '0;
        while (sb.size() > 0 && cyc < 2000) begin
            if (stalled) begin
                check("stall_key_stable",   rk_out,           held_key);
                check("stall_round_stable", 128'(rk_round),   128'(held_round));
            end
            check("valid_while_out", 128'(rk_valid), 128'd1);
            rdy      = ($urandom_range(99) >= stall_pct);
            rk_ready = rdy;
            if (poke && hs == 3) begin
                start  = 1'b1;
                key_in = ~k;
            end else begin
                start  = 1'b0;
            end
            if (rk_valid && rdy) begin
                e = sb.pop_front();
                check("sb_round", 128'(rk_round), 128'(e.round));
                check("sb_key",   rk_out,         e.key);
                hs++;
            end
            stalled    = rk_valid && !rdy;
            held_key   = rk_out;
            held_round = rk_round;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        sb.delete();
        check("handshakes", 128'(hs), 128'(NR + 1));
        if (stall_pct == 0) check("throughput_cycles", 128'(cyc), 128'(NR + 1));
        check("done_pulse",   128'(done),     128'd1);
        check("valid_dropped",128'(rk_valid), 128'd0);
        check("busy_dropped", 128'(busy),     128'd0);
        check("end_round",    128'(rk_round), 128'd0);
        check("end_key",      rk_out,         k);
        rk_ready = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 128'(done), 128'd0);
        check("retain_key",     rk_out,     k);
    endtask

    initial begin
        logic [127:0] got [0:NR];
        logic [127:0] k2;
        int           lat;

        rst       = 1'b0;
        start     = 1'b0;
        load_last = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b0;
        build_sbox();

        vectors[0] = '{1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                       128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'hac7766f319fadc2128d12941575c006e,
                       128'ha0fafe1788542cb123a339392a6c7605, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        vectors[1] = '{1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                       128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'hac7766f319fadc2128d12941575c006e,
                       128'ha0fafe1788542cb123a339392a6c7605, 128'h2b7e151628aed2a6abf7158809cf4f3c};

        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // FIPS-197 table, both load modes, rk_ready held high.
        for (int i = 0; i < 2; i++) begin
            rk_ready = 1'b1;
            send_start(vectors[i].ll, vectors[i].key_in);
            wait_valid(1'b0, lat);
            check("vec_latency", 128'(lat), vectors[i].ll ? 128'd1 : 128'(NR + 1));
            for (int n = 0; n <= NR; n++) begin
                check("vec_valid", 128'(rk_valid), 128'd1);
                check("vec_round", 128'(rk_round), 128'(NR - n));
                got[NR - n] = rk_out;
                @(negedge clk);
            end
            check("vec_r10", got[10], vectors[i].r10);
            check("vec_r9",  got[9],  vectors[i].r9);
            check("vec_r1",  got[1],  vectors[i].r1);
            check("vec_r0",  got[0],  vectors[i].r0);
            check("vec_done", 128'(done), 128'd1);
            rk_ready = 1'b0;
            @(negedge clk);
            check("vec_done_low", 128'(done), 128'd0);
        end

        // Backpressure and start-while-busy on the FIPS key.
        run_op(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 50, 1'b0);
        run_op(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 30, 1'b1);
        run_op(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 40, 1'b1);

        // Reset during EXPAND.
        send_start(1'b0, rand_key());
        repeat (3) @(negedge clk);
        check("busy_in_expand", 128'(busy), 128'd1);
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("rst_expand");
        rst = 1'b1;
        repeat (NR + 2) begin
            @(negedge clk);
            check("no_valid_after_rst1", 128'(rk_valid), 128'd0);
        end

        // Reset during OUT after three keys.
        k2 = rand_key();
        model_expand(k2);
        rk_ready = 1'b1;
        send_start(1'b1, rk_exp[NR]);
        wait_valid(1'b0, lat);
        for (int n = 0; n < 3; n++) begin
            check("pre_rst_key", rk_out, rk_exp[NR - n]);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("rst_out");
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_valid_after_rst2", 128'(rk_valid), 128'd0);
        end
        rk_ready = 1'b0;

        // Fresh start after reset, then random keys in both modes.
        run_op(rand_key(), 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(rand_key(), 1'(i % 2), (i * 13) % 60, 1'(i % 3 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
